// File: rtl/jesd204_up_rx_err_poller.sv
// JESD204 RX up-bus error poller: shares the register read port between the
// host and a lane sweep sequencer that raises sticky alarms on counter deltas.
module jesd204_up_rx_err_poller #(
    parameter int unsigned NUM_LANES      = 1,
    parameter int unsigned POLL_INTERVAL  = 1024,
    parameter int unsigned LANE_BASE_ADDR = 'h60,
    parameter logic [2:0]  ERR_CNT_OFFSET = 3'h4
) (
    input  logic                 up_clk,
    input  logic                 up_rstn,

    input  logic                 host_rreq,
    input  logic [11:0]          host_raddr,
    output logic [31:0]          host_rdata,
    output logic                 host_rack,
    input  logic                 host_wreq,
    input  logic [11:0]          host_waddr,
    input  logic [31:0]          host_wdata,

    output logic                 up_rreq,
    output logic [11:0]          up_raddr,
    input  logic [31:0]          up_rdata,
    output logic                 up_wreq,
    output logic [11:0]          up_waddr,
    output logic [31:0]          up_wdata,

    input  logic                 up_poll_enable,
    input  logic [31:0]          up_err_threshold,
    input  logic [NUM_LANES-1:0] up_alarm_clear,
    output logic [NUM_LANES-1:0] up_err_alarm,
    output logic                 up_poll_busy,
    output logic [15:0]          up_sweep_cnt
);

    localparam int unsigned LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int unsigned CNT_W  = $clog2(POLL_INTERVAL) + 1;

    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_LANES - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(POLL_INTERVAL - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_CMP  = 2'd3;

    logic [1:0]           state_q, state_d;
    logic [LANE_W-1:0]    lane_q, lane_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 abort_q, abort_d;
    logic                 busy_d;
    logic [15:0]          sweep_d;
    logic                 base_load;

    logic                 rd_owner_host_q;
    logic                 rd_done_q;
    logic                 last_host_q;
    logic                 slot_free;
    logic                 host_pend;
    logic                 poll_pend;
    logic                 grant_host;
    logic                 grant_poll;
    logic [11:0]          poll_addr;

    logic [31:0]          cur_q;
    logic [31:0]          prev_q [NUM_LANES];
    logic [NUM_LANES-1:0] base_valid_q;
    logic [31:0]          delta;
    logic [NUM_LANES-1:0] alarm_set;

    // Read-slot arbitration: one slot in flight at a time, alternating priority on contention.
    always_comb begin
        slot_free  = !up_rreq && !rd_done_q;
        host_pend  = host_rreq;
        poll_pend  = (state_q == ST_REQ) && up_poll_enable;
        grant_poll = slot_free && poll_pend && (!host_pend || last_host_q);
        grant_host = slot_free && host_pend && (!poll_pend || !last_host_q);
        poll_addr  = 12'(LANE_BASE_ADDR) + 12'({lane_q, 3'b000}) + 12'(ERR_CNT_OFFSET);
    end

    // Sequencer next-state and control.
    always_comb begin
        state_d   = state_q;
        lane_d    = lane_q;
        cnt_d     = cnt_q;
        abort_d   = abort_q;
        busy_d    = up_poll_busy;
        sweep_d   = up_sweep_cnt;
        base_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy_d  = 1'b0;
                abort_d = 1'b0;
                if (!up_poll_enable) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    lane_d  = '0;
                    busy_d  = 1'b1;
                    state_d = ST_REQ;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_REQ: begin
                if (!up_poll_enable) begin
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (grant_poll) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!up_poll_enable) begin
                    abort_d = 1'b1;
                end
                state_d = ST_CMP;
            end
            default: begin
                cnt_d = '0;
                if (abort_q || !up_poll_enable) begin
                    abort_d = 1'b0;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    base_load = 1'b1;
                    if (lane_q == LAST_LANE) begin
                        sweep_d = up_sweep_cnt + 16'd1;
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        lane_d  = lane_q + LANE_W'(1);
                        state_d = ST_REQ;
                    end
                end
            end
        endcase
    end

    // Sequencer state and status registers.
    always_ff @(posedge up_clk) begin
        if (!up_rstn) begin
            state_q      <= ST_IDLE;
            lane_q       <= '0;
            cnt_q        <= '0;
            abort_q      <= 1'b0;
            up_poll_busy <= 1'b0;
            up_sweep_cnt <= '0;
        end else begin
            state_q      <= state_d;
            lane_q       <= lane_d;
            cnt_q        <= cnt_d;
            abort_q      <= abort_d;
            up_poll_busy <= busy_d;
            up_sweep_cnt <= sweep_d;
        end
    end

    // Read pipeline: strobe, capture, deliver.
    always_ff @(posedge up_clk) begin
        if (!up_rstn) begin
            up_rreq         <= 1'b0;
            up_raddr        <= '0;
            rd_owner_host_q <= 1'b0;
            rd_done_q       <= 1'b0;
            last_host_q     <= 1'b1;
            host_rack       <= 1'b0;
            host_rdata      <= '0;
            cur_q           <= '0;
        end else begin
            up_rreq   <= grant_host || grant_poll;
            rd_done_q <= up_rreq;
            host_rack <= up_rreq && rd_owner_host_q;
            if (grant_host || grant_poll) begin
                up_raddr        <= grant_poll ? poll_addr : host_raddr;
                rd_owner_host_q <= grant_host;
                last_host_q     <= grant_host;
            end
            if (up_rreq && rd_owner_host_q) begin
                host_rdata <= up_rdata;
            end
            if (up_rreq && !rd_owner_host_q) begin
                cur_q <= up_rdata;
            end
        end
    end

    // Host writes pass through with one register stage.
    always_ff @(posedge up_clk) begin
        if (!up_rstn) begin
            up_wreq  <= 1'b0;
            up_waddr <= '0;
            up_wdata <= '0;
        end else begin
            up_wreq  <= host_wreq;
            up_waddr <= host_waddr;
            up_wdata <= host_wdata;
        end
    end

    // Delta against the stored baseline; only a valid baseline can alarm.
    always_comb begin
        alarm_set = '0;
        delta     = cur_q - prev_q[lane_q];
        if (base_load && base_valid_q[lane_q] && (delta > up_err_threshold)) begin
            alarm_set[lane_q] = 1'b1;
        end
    end

    // Sticky alarms (set beats clear) and baseline-valid tracking.
    always_ff @(posedge up_clk) begin
        if (!up_rstn) begin
            up_err_alarm <= '0;
            base_valid_q <= '0;
        end else begin
            up_err_alarm <= (up_err_alarm & ~up_alarm_clear) | alarm_set;
            if (!up_poll_enable) begin
                base_valid_q <= '0;
            end else if (base_load) begin
                base_valid_q[lane_q] <= 1'b1;
            end
        end
    end

    // Baseline sample storage; contents are ignored until marked valid.
    always_ff @(posedge up_clk) begin
        if (base_load) begin
            prev_q[lane_q] <= cur_q;
        end
    end

endmodule

// File: tb/tb_jesd204_up_rx_err_poller.sv
// Self-checking bench for jesd204_up_rx_err_poller with two lanes and a short interval.
module tb_jesd204_up_rx_err_poller;

    localparam int unsigned NL = 2;
    localparam logic [11:0] LANE0 = 12'h064;
    localparam logic [11:0] LANE1 = 12'h06C;

    logic          up_clk = 1'b0;
    logic          up_rstn;
    logic          host_rreq;
    logic [11:0]   host_raddr;
    logic [31:0]   host_rdata;
    logic          host_rack;
    logic          host_wreq;
    logic [11:0]   host_waddr;
    logic [31:0]   host_wdata;
    logic          up_rreq;
    logic [11:0]   up_raddr;
    logic [31:0]   up_rdata;
    logic          up_wreq;
    logic [11:0]   up_waddr;
    logic [31:0]   up_wdata;
    logic          up_poll_enable;
    logic [31:0]   up_err_threshold;
    logic [NL-1:0] up_alarm_clear;
    logic [NL-1:0] up_err_alarm;
    logic          up_poll_busy;
    logic [15:0]   up_sweep_cnt;

    int total = 0;
    int bad   = 0;

    logic [31:0] lane_cnt [NL];
    logic [31:0] m_prev   [NL];
    logic [NL-1:0] m_valid;
    logic [NL-1:0] exp_alarm;
    logic [15:0]   exp_sweeps;
    logic [11:0]   pq [$];
    bit            own_q [$];

    jesd204_up_rx_err_poller #(
        .NUM_LANES(NL), .POLL_INTERVAL(16), .LANE_BASE_ADDR('h60), .ERR_CNT_OFFSET(3'h4)
    ) dut (
        .up_clk(up_clk), .up_rstn(up_rstn),
        .host_rreq(host_rreq), .host_raddr(host_raddr), .host_rdata(host_rdata), .host_rack(host_rack),
        .host_wreq(host_wreq), .host_waddr(host_waddr), .host_wdata(host_wdata),
        .up_rreq(up_rreq), .up_raddr(up_raddr), .up_rdata(up_rdata),
        .up_wreq(up_wreq), .up_waddr(up_waddr), .up_wdata(up_wdata),
        .up_poll_enable(up_poll_enable), .up_err_threshold(up_err_threshold),
        .up_alarm_clear(up_alarm_clear), .up_err_alarm(up_err_alarm),
        .up_poll_busy(up_poll_busy), .up_sweep_cnt(up_sweep_cnt)
    );

    always #5 up_clk = ~up_clk;

    // Register bus model: lane counters at their addresses, address-tagged pattern elsewhere.
    always_comb begin
        if (up_raddr == LANE0)      up_rdata = lane_cnt[0];
        else if (up_raddr == LANE1) up_rdata = lane_cnt[1];
        else                        up_rdata = {20'hA5A5A, up_raddr};
    end

    // Bus monitor: log every read strobe and who it belonged to.
    always @(negedge up_clk) begin
        if (up_rstn && up_rreq) begin
            if (up_raddr == LANE0 || up_raddr == LANE1) begin
                pq.push_back(up_raddr);
                own_q.push_back(1'b1);
            end else begin
                own_q.push_back(1'b0);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: one full sweep compares each lane against its previous sample.
    task automatic model_sweep();
        for (int i = 0; i < NL; i++) begin
            if (m_valid[i] && ((lane_cnt[i] - m_prev[i]) > up_err_threshold)) exp_alarm[i] = 1'b1;
            m_prev[i]  = lane_cnt[i];
            m_valid[i] = 1'b1;
        end
    endtask

    task automatic pulse_clear(input logic [NL-1:0] c);
        up_alarm_clear = c;
        @(posedge up_clk); #1;
        up_alarm_clear = '0;
        exp_alarm = exp_alarm & ~c;
        check("clear_only", 32'(up_err_alarm), 32'(exp_alarm));
    endtask

    task automatic do_sweep(input string tag);
        int n = 0;
        while (up_sweep_cnt == exp_sweeps && n < 300) begin
            @(negedge up_clk);
            n++;
        end
        if (n >= 300) check({tag, "_timeout"}, 32'(n), 32'd0);
        exp_sweeps = exp_sweeps + 16'd1;
        model_sweep();
        check({tag, "_sweep_cnt"}, 32'(up_sweep_cnt), 32'(exp_sweeps));
        check({tag, "_alarm"}, 32'(up_err_alarm), 32'(exp_alarm));
        check({tag, "_busy"}, 32'(up_poll_busy), 32'd0);
        check({tag, "_nreads"}, 32'(pq.size()), 32'd2);
        if (pq.size() == 2) begin
            check({tag, "_addr0"}, 32'(pq[0]), 32'(LANE0));
            check({tag, "_addr1"}, 32'(pq[1]), 32'(LANE1));
        end
        pq.delete();
        @(posedge up_clk); #1;
    endtask

    task automatic host_read(input logic [11:0] a, output int lat, output logic [31:0] d);
        host_raddr = a;
        host_rreq  = 1'b1;
        lat = 0;
        while (1) begin
            @(negedge up_clk);
            if (host_rack) break;
            lat++;
            if (lat > 50) break;
        end
        d = host_rdata;
        @(posedge up_clk); #1;
        host_rreq = 1'b0;
    endtask

    task automatic wait_lane0_read(output int n);
        n = 0;
        while (!(up_rreq && up_raddr == LANE0) && n < 300) begin
            @(negedge up_clk);
            n++;
        end
        if (n >= 300) check("lane0_wait_timeout", 32'(n), 32'd0);
    endtask

    initial begin
        int lat;
        int n;
        int idx;
        logic [31:0] d;
        logic [31:0] thr;
        logic [NL-1:0] clr;

        up_rstn = 1'b0; host_rreq = 1'b0; host_raddr = '0; host_wreq = 1'b0;
        host_waddr = '0; host_wdata = '0; up_poll_enable = 1'b0;
        up_err_threshold = 32'd3; up_alarm_clear = '0;
        lane_cnt[0] = 32'd100; lane_cnt[1] = 32'd200;
        m_prev[0] = '0; m_prev[1] = '0; m_valid = '0; exp_alarm = '0; exp_sweeps = '0;

        repeat (3) @(posedge up_clk);
        @(negedge up_clk);
        check("rst_rack", 32'(host_rack), 32'd0);
        check("rst_rreq", 32'(up_rreq), 32'd0);
        check("rst_wreq", 32'(up_wreq), 32'd0);
        check("rst_alarm", 32'(up_err_alarm), 32'd0);
        check("rst_busy", 32'(up_poll_busy), 32'd0);
        check("rst_sweep", 32'(up_sweep_cnt), 32'd0);
        @(posedge up_clk); #1;
        up_rstn = 1'b1;
        @(posedge up_clk); #1;
        pq.delete(); own_q.delete();

        // Host read with poller idle: strobe one cycle later, ack two cycles later.
        host_raddr = 12'h0a0; host_rreq = 1'b1;
        @(negedge up_clk);
        check("h_rreq_n0", 32'(up_rreq), 32'd0);
        @(negedge up_clk);
        check("h_rreq_n1", 32'(up_rreq), 32'd1);
        check("h_raddr_n1", 32'(up_raddr), 32'h0a0);
        check("h_rack_n1", 32'(host_rack), 32'd0);
        @(negedge up_clk);
        check("h_rack_n2", 32'(host_rack), 32'd1);
        check("h_rdata", host_rdata, {20'hA5A5A, 12'h0a0});
        check("h_rreq_n2", 32'(up_rreq), 32'd0);
        @(posedge up_clk); #1;
        host_rreq = 1'b0;
        @(negedge up_clk);
        check("h_rack_pulse", 32'(host_rack), 32'd0);
        @(posedge up_clk); #1;

        // Write passthrough with one cycle of delay.
        for (int i = 0; i < 3; i++) begin
            logic [11:0] wa;
            logic [31:0] wd;
            wa = 12'($urandom); wd = $urandom;
            host_wreq = 1'b1; host_waddr = wa; host_wdata = wd;
            @(posedge up_clk); #1;
            host_wreq = 1'b0;
            check("w_req", 32'(up_wreq), 32'd1);
            check("w_addr", 32'(up_waddr), 32'(wa));
            check("w_data", up_wdata, wd);
            @(posedge up_clk); #1;
            check("w_req_drop", 32'(up_wreq), 32'd0);
        end

        // Baseline sweep, then lane 0 rises by 5 against threshold 3.
        pq.delete();
        up_poll_enable = 1'b1;
        do_sweep("base");
        lane_cnt[0] = 32'd105;
        do_sweep("inc5");
        check("inc5_alarm_const", 32'(up_err_alarm), 32'h1);

        // Counter wrap: FFFFFFFE -> 2 is a delta of 4.
        pulse_clear(2'b01);
        lane_cnt[0] = 32'hFFFF_FFFE;
        do_sweep("pre_wrap");
        pulse_clear(2'b01);
        lane_cnt[0] = 32'h0000_0002;
        do_sweep("wrap");
        check("wrap_alarm0", 32'(up_err_alarm[0]), 32'd1);

        // Clear and set on lane 0 in the same cycle: set wins.
        lane_cnt[0] = lane_cnt[0] + 32'd10;
        wait_lane0_read(n);
        check("busy_in_sweep", 32'(up_poll_busy), 32'd1);
        @(posedge up_clk); #1;
        up_alarm_clear = 2'b01;
        @(posedge up_clk); #1;
        up_alarm_clear = '0;
        exp_alarm = exp_alarm & ~2'b01;
        do_sweep("clr_set");
        check("clr_set_alarm0", 32'(up_err_alarm[0]), 32'd1);

        // Randomized sweeps around the threshold, including 0 and all-ones.
        for (int it = 0; it < 8; it++) begin
            clr = NL'($urandom_range(0, 3));
            pulse_clear(clr);
            case ($urandom_range(0, 3))
                0: thr = 32'd0;
                1: thr = 32'hFFFF_FFFF;
                default: thr = 32'($urandom_range(0, 5));
            endcase
            up_err_threshold = thr;
            for (int l = 0; l < NL; l++) begin
                if (thr == 32'hFFFF_FFFF) lane_cnt[l] = lane_cnt[l] + $urandom;
                else                      lane_cnt[l] = lane_cnt[l] + 32'($urandom_range(0, 6));
            end
            do_sweep("rnd");
        end

        // Enable dropped while the lane 0 read is in flight.
        pulse_clear(2'b11);
        up_err_threshold = 32'd0;
        lane_cnt[0] = lane_cnt[0] + 32'd1000;
        lane_cnt[1] = lane_cnt[1] + 32'd1000;
        wait_lane0_read(n);
        up_poll_enable = 1'b0;
        m_valid = '0;
        repeat (4) @(negedge up_clk);
        check("abort_busy", 32'(up_poll_busy), 32'd0);
        check("abort_alarm", 32'(up_err_alarm), 32'(exp_alarm));
        check("abort_sweep", 32'(up_sweep_cnt), 32'(exp_sweeps));
        pq.delete();
        lane_cnt[0] = lane_cnt[0] + 32'd50;
        lane_cnt[1] = lane_cnt[1] + 32'd50;
        @(posedge up_clk); #1;
        up_poll_enable = 1'b1;
        do_sweep("rebase");
        check("rebase_alarm_zero", 32'(up_err_alarm), 32'd0);
        lane_cnt[1] = lane_cnt[1] + 32'd7;
        do_sweep("post_rebase");

        // Continuous host reads across a sweep: contention alternates grants.
        own_q.delete();
        for (int i = 0; i < 30; i++) begin
            logic [11:0] ha;
            ha = 12'h0a0 + 12'(i);
            host_read(ha, lat, d);
            if (lat > 50) check("arb_rack_timeout", 32'(lat), 32'd0);
            check("arb_rdata", d, {20'hA5A5A, ha});
        end
        idx = -1;
        for (int i = 0; i < own_q.size(); i++) begin
            if (own_q[i] && idx < 0) idx = i;
        end
        check("arb_found_poll", 32'(idx >= 1 && idx + 2 < own_q.size()), 32'd1);
        if (idx >= 1 && idx + 2 < own_q.size()) begin
            check("arb_prev_host", 32'(own_q[idx-1]), 32'd0);
            check("arb_then_host", 32'(own_q[idx+1]), 32'd0);
            check("arb_then_poll", 32'(own_q[idx+2]), 32'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
